// File: rtl/series_job_dispatcher.sv
// Job front-end for the series-evaluation engine: queues (x, y) operand pairs,
// launches one engine job at a time and registers each result (or timeout) for a consumer.
`timescale 1ns/1ps

module series_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [9:0]               in_x_i,
    input  logic [7:0]               in_y_i,
    output logic                     eng_start_o,
    output logic [9:0]               eng_x_o,
    output logic [7:0]               eng_y_o,
    input  logic                     eng_done_i,
    input  logic [9:0]               eng_result_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [9:0]               out_result_o,
    output logic                     out_err_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      eng_x_q, eng_x_d;
    logic [7:0]      eng_y_q, eng_y_d;
    logic [9:0]      res_q, res_d;
    logic            err_q, err_d;

    logic [9:0]      mem_x_q [DEPTH];
    logic [7:0]      mem_y_q [DEPTH];

    logic            push;
    logic            pop;

    assign in_ready_o = rst_ni && (count_q < CW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (state_q == ST_IDLE) && (count_q != '0);

    // Storage needs no reset: occupancy is tracked solely by count_q and the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_x_q[wr_ptr_q] <= in_x_i;
            mem_y_q[wr_ptr_q] <= in_y_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        eng_x_d = eng_x_q;
        eng_y_d = eng_y_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    eng_x_d = mem_x_q[rd_ptr_q];
                    eng_y_d = mem_y_q[rd_ptr_q];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the final allowed cycle beats the timeout.
                if (eng_done_i) begin
                    res_d   = eng_result_i;
                    err_d   = 1'b0;
                    state_d = ST_HOLD;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            eng_x_q  <= '0;
            eng_y_q  <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            eng_x_q  <= eng_x_d;
            eng_y_q  <= eng_y_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    assign eng_start_o  = (state_q == ST_LAUNCH);
    assign eng_x_o      = eng_x_q;
    assign eng_y_o      = eng_y_q;
    assign out_valid_o  = (state_q == ST_HOLD);
    assign out_result_o = res_q;
    assign out_err_o    = err_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign count_o      = count_q;

endmodule
